tenkey_scan: RTL and testbench

Keypad front end that drives the 4x3 tenkey matrix, debounces it and delivers clean one-hot key strobes to the electronic lock. It sits between the physical keypad pins and the lock's `tenkey[9:0]` input. Each debounced press produces exactly one single-cycle one-hot pulse, so the lock's key shift register advances once per press. Keys `*` and `#` are reported on separate strobes.

---
 rtl/tenkey_scan.sv | 149 ++++++++++++++
 tb/tb_tenkey_scan.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tenkey_scan.sv
// 4x3 keypad scanner: drives the columns, debounces whole-matrix snapshots
// and emits one registered one-hot strobe per accepted key press.
module tenkey_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] tenkey,
  output logic       star,
  output logic       hash,
  output logic       key_valid,
  output logic [3:0] digit
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);

  typedef enum logic {RELEASED, HELD} state_t;

  state_t            state, state_nxt;
  logic [3:0]        sync1, sync2;
  logic [SLOT_W-1:0] slot;
  logic [11:0]       acc, snap, prev;
  logic [CNT_W-1:0]  cnt, cnt_upd;
  logic              sample, frame_end, stable, one_hot;
  logic [3:0]        code;
  logic [9:0]        tenkey_nxt;
  logic              star_nxt, hash_nxt, valid_nxt;
  logic [3:0]        digit_nxt;

  assign sample    = (slot == SLOT_LAST);
  assign frame_end = sample & col[2];

  // Snapshot as it would look if the current column were captured now.
  always_comb begin
    snap = acc;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (col[c]) snap[r*3 + c] = sync2[r];
      end
    end
  end

  always_comb begin
    if (snap == prev) cnt_upd = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    else              cnt_upd = '0;
  end

  assign stable  = (cnt_upd == CNT_MAX);
  assign one_hot = (snap != 12'd0) && ((snap & (snap - 12'd1)) == 12'd0);

  // Matrix bit (row*3 + column) to key code; * = A, # = B.
  always_comb begin
    case (snap)
      12'h001: code = 4'd1;
      12'h002: code = 4'd2;
      12'h004: code = 4'd3;
      12'h008: code = 4'd4;
      12'h010: code = 4'd5;
      12'h020: code = 4'd6;
      12'h040: code = 4'd7;
      12'h080: code = 4'd8;
      12'h100: code = 4'd9;
      12'h200: code = 4'hA;
      12'h400: code = 4'd0;
      12'h800: code = 4'hB;
      default: code = 4'hF;
    endcase
  end

  // Synchronizer, column scan and frame debounce datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      slot  <= '0;
      col   <= 3'b001;
      acc   <= '0;
      prev  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= row;
      sync2 <= sync1;
      if (sample) begin
        slot <= '0;
        col  <= {col[1:0], col[2]};
        acc  <= snap;
      end else begin
        slot <= slot + SLOT_W'(1);
      end
      if (frame_end) begin
        prev <= snap;
        cnt  <= cnt_upd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RELEASED;
      tenkey    <= '0;
      star      <= 1'b0;
      hash      <= 1'b0;
      key_valid <= 1'b0;
      digit     <= 4'hF;
    end else begin
      state     <= state_nxt;
      tenkey    <= tenkey_nxt;
      star      <= star_nxt;
      hash      <= hash_nxt;
      key_valid <= valid_nxt;
      digit     <= digit_nxt;
    end
  end

  // Press/release tracking; only a clean single key from RELEASED strobes.
  always_comb begin
    state_nxt  = state;
    tenkey_nxt = '0;
    star_nxt   = 1'b0;
    hash_nxt   = 1'b0;
    valid_nxt  = 1'b0;
    digit_nxt  = digit;
    if (frame_end && stable) begin
      case (state)
        RELEASED: begin
          if (one_hot) begin
            state_nxt = HELD;
            valid_nxt = 1'b1;
            digit_nxt = code;
            if (code < 4'd10)       tenkey_nxt = 10'd1 << code;
            else if (code == 4'hA)  star_nxt   = 1'b1;
            else                    hash_nxt   = 1'b1;
          end
        end
        HELD: begin
          if (snap == 12'd0) state_nxt = RELEASED;
        end
        default: state_nxt = RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_tenkey_scan.sv
// Directed bench for tenkey_scan: keypad model, strobe monitor and
// hand-computed expectations with SCAN_DIV=4, DEBOUNCE=2 (12-cycle frames).
module tb_tenkey_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [2:0] col;
  logic [9:0] tenkey;
  logic       star, hash, key_valid;
  logic [3:0] digit;

  logic [11:0] held = '0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          t0;

  typedef struct {
    logic [9:0] tk;
    logic       st;
    logic       hs;
    logic [3:0] dg;
    int         cy;
  } ev_t;
  ev_t ev_q[$];

  tenkey_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .tenkey(tenkey),
    .star(star), .hash(hash), .key_valid(key_valid), .digit(digit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a held key shorts its column drive onto its row.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = |(held[r*3 +: 3] & col);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      ev_q.push_back('{tk: tenkey, st: star, hs: hash, dg: digit, cy: cyc});
      check("strobe_onehot", 32'($countones({tenkey, star, hash})), 32'd1);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe expected, with fields and edge number.
  task automatic check_one(input string tag, input logic [9:0] tk, input logic st,
                           input logic hs, input logic [3:0] dg, input int cy);
    check({tag, "_count"}, 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) begin
      check({tag, "_tenkey"}, 32'(ev_q[0].tk), 32'(tk));
      check({tag, "_star"},   32'(ev_q[0].st), 32'(st));
      check({tag, "_hash"},   32'(ev_q[0].hs), 32'(hs));
      check({tag, "_digit"},  32'(ev_q[0].dg), 32'(dg));
      if (cy >= 0) check({tag, "_cycle"}, 32'(ev_q[0].cy), 32'(cy));
    end
    ev_q.delete();
  endtask

  task automatic release_all();
    held = '0;
    wait_cyc(48);
    ev_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    wait_cyc(3);
    check("rst_col",    32'(col), 32'h1);
    check("rst_tenkey", 32'(tenkey), 32'h0);
    check("rst_star",   32'(star), 32'h0);
    check("rst_hash",   32'(hash), 32'h0);
    check("rst_valid",  32'(key_valid), 32'h0);
    check("rst_digit",  32'(digit), 32'hF);
    reset = 1'b0;
    wait_cyc(24);

    // Key 3 held 10 frames: exactly one strobe, 3 frames after press.
    held = 12'h004; t0 = cyc;
    wait_cyc(120);
    check_one("key3", 10'b0000001000, 1'b0, 1'b0, 4'd3, t0 + 36);
    release_all();

    // Key 7 (row 2, column 0).
    held = 12'h040; t0 = cyc;
    wait_cyc(60);
    check_one("key7", 10'b0010000000, 1'b0, 1'b0, 4'd7, t0 + 36);
    release_all();

    // Keys 1 and 5 together: nothing, digit keeps 7.
    held = 12'h011;
    wait_cyc(72);
    held = '0;
    wait_cyc(48);
    check("multi_count", 32'(ev_q.size()), 32'd0);
    check("multi_digit", 32'(digit), 32'd7);
    ev_q.delete();
    held = 12'h010; t0 = cyc;
    wait_cyc(60);
    check_one("key5", 10'b0000100000, 1'b0, 1'b0, 4'd5, t0 + 36);
    release_all();

    // Key 9 bouncing on alternate frames, then steady.
    for (int f = 0; f < 6; f++) begin
      held = (f % 2 == 0) ? 12'h100 : 12'h000;
      wait_cyc(12);
    end
    check("bounce_count", 32'(ev_q.size()), 32'd0);
    held = 12'h100; t0 = cyc;
    wait_cyc(60);
    check_one("key9", 10'b1000000000, 1'b0, 1'b0, 4'd9, t0 + 36);
    release_all();

    // Star then hash.
    held = 12'h200; t0 = cyc;
    wait_cyc(60);
    check_one("star", 10'b0, 1'b1, 1'b0, 4'hA, t0 + 36);
    release_all();
    held = 12'h800; t0 = cyc;
    wait_cyc(60);
    check_one("hash", 10'b0, 1'b0, 1'b1, 4'hB, t0 + 36);
    release_all();

    // Key 0 held through a reset that hits during its strobe.
    held = 12'h400;
    for (int i = 0; i < 60 && key_valid !== 1'b1; i++) @(negedge clk);
    check("key0_pre_strobe", 32'(key_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_tenkey", 32'(tenkey), 32'h0);
    check("midrst_valid",  32'(key_valid), 32'h0);
    check("midrst_digit",  32'(digit), 32'hF);
    check("midrst_col",    32'(col), 32'h1);
    wait_cyc(2);
    reset = 1'b0;
    t0 = cyc;
    ev_q.delete();
    wait_cyc(60);
    check_one("key0", 10'b0000000001, 1'b0, 1'b0, 4'd0, t0 + 36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
